// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared constants for the SIPO frame sequencer: state encoding and board defaults.
package sipo_pkg;
  localparam int WIDTH_DEF    = 8;
  localparam int TICK_DIV_DEF = 50000000;
  localparam int CNT_W_DEF    = 26;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_LATCH = 2'd2;
endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Board-pin / SIPO-side bundle of the frame sequencer.
interface sipo_frame_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             btn;
  logic             start_btn;
  logic             abort_btn;
  logic [WIDTH-1:0] sipo_q;
  logic             shift_en;
  logic             sdo;
  logic [WIDTH-1:0] led;
  logic             busy;
  logic             frame_done;

  modport slave (
    input  btn, start_btn, abort_btn, sipo_q,
    output shift_en, sdo, led, busy, frame_done
  );

  modport master (
    output btn, start_btn, abort_btn, sipo_q,
    input  shift_en, sdo, led, busy, frame_done
  );
endinterface

// File: rtl/sipo_frame_ctrl_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer: timed shift strobes into the SIPO, WIDTH-bit frame count, LED latch.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  sipo_frame_if.slave  io
);
  localparam int                BW        = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [BW-1:0]     BIT_LAST  = BW'(WIDTH - 1);

  logic             sync_btn, sync_start, sync_abort, start_d;
  logic             start_edge, tick_last, last_bit;
  state_t           state, state_nx;
  logic [CNT_W-1:0] tick;
  logic [BW-1:0]    bit_cnt;
  logic             shift_en, frame_done, busy;
  logic [WIDTH-1:0] led;

  sync2 u_sync_btn   (.clk(clk), .rst_n(rst_n), .d(io.btn),       .q(sync_btn));
  sync2 u_sync_start (.clk(clk), .rst_n(rst_n), .d(io.start_btn), .q(sync_start));
  sync2 u_sync_abort (.clk(clk), .rst_n(rst_n), .d(io.abort_btn), .q(sync_abort));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_d <= 1'b0;
    else        start_d <= sync_start;
  end

  assign start_edge = sync_start & ~start_d;
  assign tick_last  = (tick == TICK_LAST);
  assign last_bit   = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // LATCH only ever returns to IDLE, so a start edge coinciding with it is dropped.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_edge && !sync_abort) state_nx = S_SHIFT;
      S_SHIFT: begin
        if (sync_abort)                 state_nx = S_IDLE;
        else if (tick_last && last_bit) state_nx = S_LATCH;
      end
      S_LATCH: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = tick_last & ~sync_abort;
      end
      S_LATCH: begin
        busy       = 1'b1;
        frame_done = ~sync_abort;
      end
      default: ;
    endcase
  end

  // Counters park at zero outside SHIFT, so entry into SHIFT always starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick    <= '0;
      bit_cnt <= '0;
    end else if (state == S_SHIFT && !sync_abort) begin
      tick <= tick_last ? '0 : tick + CNT_W'(1);
      if (shift_en) bit_cnt <= bit_cnt + BW'(1);
    end else begin
      tick    <= '0;
      bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          led <= '0;
    else if (frame_done) led <= io.sipo_q;
  end

  assign io.shift_en   = shift_en;
  assign io.sdo        = sync_btn;
  assign io.led        = led;
  assign io.busy       = busy;
  assign io.frame_done = frame_done;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl with a behavioural SIPO on the parallel input.
module tb_sipo_frame_ctrl;
  localparam int W  = 8;
  localparam int TD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sipo_frame_if #(.WIDTH(W)) io ();

  sipo_frame_ctrl #(.WIDTH(W), .TICK_DIV(TD), .CNT_W(26)) dut (
    .clk(clk), .rst_n(rst_n), .io(io)
  );

  // SIPO register: shifts toward the MSB, so the first bit of a frame lands at bit W-1
  logic [W-1:0] sipo;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           sipo <= '0;
    else if (io.shift_en) sipo <= {sipo[W-2:0], io.sdo};
  end
  assign io.sipo_q = sipo;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen / not allowed at %0t", name, $time);
  endtask

  // Monitor: spacing and count of shifts, one frame_done per expected frame, LED value
  int           ns     = 0;
  time          last_t = 0;
  logic         chk_led = 1'b0;
  logic [W-1:0] exp_led = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ns      = 0;
      chk_led = 1'b0;
    end else begin
      if (chk_led) begin
        check("led_after_frame", 32'(io.led), 32'(exp_led));
        chk_led = 1'b0;
      end
      if (io.shift_en && io.frame_done) fail_now("shift_en_with_frame_done");
      if (io.shift_en) begin
        if (ns > 0) check("shift_spacing", 32'(($time - last_t) / 10), 32'(TD));
        last_t = $time;
        ns++;
      end
      if (io.frame_done) begin
        check("shifts_per_frame", 32'(ns), 32'(W));
        ns = 0;
        if (exp_q.size() == 0) fail_now("unexpected_frame_done");
        else begin
          exp_led = exp_q.pop_front();
          chk_led = 1'b1;
        end
      end else if (!io.busy) begin
        ns = 0;
      end
    end
  end

  task automatic wait_shift(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (io.shift_en) ok = 1'b1;
    end
    if (!ok) fail_now("shift_timeout");
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!io.busy) done = 1'b1;
    end
    if (!done) fail_now("idle_timeout");
  endtask

  task automatic pulse_start();
    io.start_btn = 1'b1;
    repeat (3) @(negedge clk);
    io.start_btn = 1'b0;
  endtask

  // Waits for shifts from..to-1, presenting the next bit right after each shift
  task automatic feed(input logic [W-1:0] bits, input int from, input int to);
    bit ok;
    for (int i = from; i < to; i++) begin
      wait_shift(ok);
      if (!ok) return;
      if (i < W - 1) io.btn = bits[W-2-i];
    end
  endtask

  task automatic start_frame(input logic [W-1:0] bits);
    time t0;
    bit  ok;
    @(negedge clk);
    io.btn = bits[W-1];
    t0 = $time;
    pulse_start();
    check("busy_after_start", 32'(io.busy), 32'd1);
    wait_shift(ok);
    check("first_shift_latency", 32'(($time - t0) / 10), 32'd6);
    io.btn = bits[W-2];
  endtask

  initial begin
    logic [W-1:0] a, b;
    time t0;
    bit  ok;
    io.btn = 1'b0; io.start_btn = 1'b0; io.abort_btn = 1'b0;

    // Reset held with inputs toggling
    repeat (4) @(negedge clk) begin
      io.btn = ~io.btn; io.start_btn = ~io.start_btn; io.abort_btn = ~io.abort_btn;
    end
    check("rst_busy",       32'(io.busy),       32'd0);
    check("rst_shift_en",   32'(io.shift_en),   32'd0);
    check("rst_frame_done", 32'(io.frame_done), 32'd0);
    check("rst_led",        32'(io.led),        32'd0);
    check("rst_sdo",        32'(io.sdo),        32'd0);
    io.start_btn = 1'b0; io.abort_btn = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk) io.btn = ~io.btn;
    check("idle_led", 32'(io.led),  32'd0);
    check("idle_busy", 32'(io.busy), 32'd0);

    // Basic frame
    a = 8'b10110010;
    exp_q.push_back(a);
    start_frame(a);
    feed(a, 1, W);
    wait_idle();
    @(negedge clk);
    check("post_frame_done", 32'(io.frame_done), 32'd0);
    check("post_frame_shift", 32'(io.shift_en), 32'd0);
    repeat (2) @(negedge clk);

    // Start edge mid-frame is ignored
    a = 8'hCA;
    exp_q.push_back(a);
    start_frame(a);
    feed(a, 1, 3);
    pulse_start();
    check("restart_busy", 32'(io.busy), 32'd1);
    feed(a, 3, W);
    wait_idle();
    repeat (2) @(negedge clk);

    // Abort after the fifth shift
    a = 8'b01110001;
    start_frame(a);
    feed(a, 1, 5);
    io.abort_btn = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", 32'(io.busy), 32'd0);
    check("abort_led_kept", 32'(io.led), 32'hCA);
    pulse_start();
    repeat (2) @(negedge clk);
    check("start_under_abort", 32'(io.busy), 32'd0);
    io.abort_btn = 1'b0;
    repeat (4) @(negedge clk);

    // Async reset between clock edges, mid-SHIFT
    a = 8'b10011110;
    start_frame(a);
    feed(a, 1, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_led",        32'(io.led),        32'd0);
    check("arst_busy",       32'(io.busy),       32'd0);
    check("arst_shift_en",   32'(io.shift_en),   32'd0);
    check("arst_frame_done", 32'(io.frame_done), 32'd0);
    check("arst_sdo",        32'(io.sdo),        32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    a = 8'h27;
    exp_q.push_back(a);
    start_frame(a);
    feed(a, 1, W);
    wait_idle();
    repeat (2) @(negedge clk);

    // Back-to-back: start edge lands in the IDLE cycle right after LATCH
    a = 8'hF0;
    b = 8'h55;
    exp_q.push_back(a);
    exp_q.push_back(b);
    start_frame(a);
    feed(a, 1, W);
    io.btn = b[W-1];
    io.start_btn = 1'b1;
    t0 = $time;
    repeat (2) @(negedge clk);
    check("b2b_idle_gap", 32'(io.busy), 32'd0);
    wait_shift(ok);
    check("b2b_first_shift_latency", 32'(($time - t0) / 10), 32'd6);
    io.start_btn = 1'b0;
    io.btn = b[W-2];
    feed(b, 1, W);
    wait_idle();
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
